// File: rtl/seg_display_ctrl_pkg.sv
// Shared definitions for the seven-segment display controller:
// input modes, controller states and active-low segment patterns.
package seg_pkg;

  localparam logic [1:0] MODE_UDEC = 2'b00;
  localparam logic [1:0] MODE_SDEC = 2'b01;
  localparam logic [1:0] MODE_HEX  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LOAD    = 2'd2
  } state_e;

  // Patterns are {g,f,e,d,c,b,a}, a segment is lit when its bit is 0.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] seg_of_nibble(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_bcd_dd_iter.sv
// Iterative double-dabble: one add-3/shift step per clock, WIDTH steps per
// conversion. Any BCD bit lost off the top leaves ovf set until the next start.
module bcd_dd_iter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCDW-1:0]  bcd_q, bcd_d;
  logic [BCDW-1:0]  adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                          : bcd_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    ovf_d  = ovf_q;
    if (start) begin
      bin_d  = bin;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
      ovf_d  = 1'b0;
    end else if (busy_q) begin
      bcd_d = {adj[BCDW-2:0], bin_q[WIDTH-1]};
      bin_d = {bin_q[WIDTH-2:0], 1'b0};
      ovf_d = ovf_q | adj[BCDW-1];
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  // done marks the final step: bcd/ovf hold the finished result from the next cycle.
  assign done = busy_q && (cnt_q == CNT_LAST);
  assign busy = busy_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: accepts a value over valid/ready, converts
// it (decimal or hex), builds the digit image in one LOAD cycle and scans it.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_value,
  input  logic [1:0]        mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [6:0]        SEG,
  output logic [DIGITS-1:0] AN,
  output logic              DP,
  output logic              overflow
);

  localparam int BCDW = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIVW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDXW-1:0]   IDX_LAST = IDXW'(DIGITS - 1);
  localparam logic [IDXW-1:0]   IDX_ONE  = IDXW'(1);
  localparam logic [DIVW-1:0]   DIV_LAST = DIVW'(REFRESH_DIV - 1);
  localparam logic [DIVW-1:0]   DIV_ONE  = DIVW'(1);
  localparam logic [WIDTH-1:0]  W_ONE    = WIDTH'(1);
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             neg_q, neg_d;
  logic             hex_q, hex_d;
  logic             blank_q, blank_d;
  logic             ovf_q, ovf_d;
  logic [6:0]       disp_q [DIGITS];
  logic [6:0]       disp_d [DIGITS];

  logic             in_is_hex, in_neg;
  logic             dd_start, dd_busy, dd_done, dd_ovf;
  logic [WIDTH-1:0] dd_bin;
  logic [BCDW-1:0]  dd_bcd;

  logic [BCDW-1:0]  hex_nib;
  logic             hex_ovf;
  logic [3:0]       nib [DIGITS];
  logic [6:0]       img [DIGITS];
  logic             img_ovf, sign_hit, sign_ovf;
  int               msd, sign_pos;

  assign in_is_hex = mode[1];
  assign in_neg    = (mode == MODE_SDEC) && in_value[WIDTH-1];
  assign dd_bin    = in_neg ? (~in_value + W_ONE) : in_value;
  assign in_ready  = (state_q == ST_IDLE);

  bcd_dd_iter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_dd (
    .clk   (clk),
    .reset (reset),
    .start (dd_start),
    .bin   (dd_bin),
    .busy  (dd_busy),
    .done  (dd_done),
    .bcd   (dd_bcd),
    .ovf   (dd_ovf)
  );

  // Hex digits read the latched value zero-extended to the display width.
  genvar gi;
  generate
    for (gi = 0; gi < BCDW; gi++) begin : g_hex
      if (gi < WIDTH) begin : g_bit
        assign hex_nib[gi] = value_q[gi];
      end else begin : g_pad
        assign hex_nib[gi] = 1'b0;
      end
    end
    if (WIDTH > BCDW) begin : g_hex_ovf
      assign hex_ovf = |value_q[WIDTH-1:BCDW];
    end else begin : g_no_hex_ovf
      assign hex_ovf = 1'b0;
    end
  endgenerate

  always_comb begin
    msd      = 0;
    sign_pos = 0;
    sign_hit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nib[i] = hex_q ? hex_nib[4*i +: 4] : dd_bcd[4*i +: 4];
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (nib[i] != 4'd0) msd = i;
    end
    sign_pos = blank_q ? msd + 1 : DIGITS - 1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i == sign_pos) && (nib[i] != 4'd0)) sign_hit = 1'b1;
    end
    sign_ovf = neg_q && ((sign_pos > DIGITS - 1) || sign_hit);
    img_ovf  = hex_q ? hex_ovf : (dd_ovf || sign_ovf);
    for (int i = 0; i < DIGITS; i++) begin
      if (img_ovf || (neg_q && (i == sign_pos))) begin
        img[i] = SEG_MINUS;
      end else if (blank_q && (i > msd)) begin
        img[i] = SEG_BLANK;
      end else begin
        img[i] = seg_of_nibble(nib[i]);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    neg_d    = neg_q;
    hex_d    = hex_q;
    blank_d  = blank_q;
    ovf_d    = ovf_q;
    disp_d   = disp_q;
    dd_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          value_d = in_value;
          neg_d   = in_neg;
          hex_d   = in_is_hex;
          blank_d = blank_lz;
          if (in_is_hex) begin
            state_d = ST_LOAD;
          end else begin
            dd_start = 1'b1;
            state_d  = ST_CONVERT;
          end
        end
      end
      // The !dd_busy term only guards against a converter that never started.
      ST_CONVERT: begin
        if (dd_done || !dd_busy) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        disp_d  = img;
        ovf_d   = img_ovf;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      neg_q   <= 1'b0;
      hex_q   <= 1'b0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      neg_q   <= neg_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
    end
  end

  // Scan: the divider paces the digit index, outputs are registered from it.
  logic [DIVW-1:0]   div_q, div_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              dp_q, dp_d;

  always_comb begin
    div_d = div_q + DIV_ONE;
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
    end
    seg_d = disp_q[idx_q];
    an_d  = ~(AN_ONE << idx_q);
    dp_d  = ~dp_mask[idx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= ~AN_ONE;
      dp_q  <= ~dp_mask[0];
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign SEG      = seg_q;
  assign AN       = an_q;
  assign DP       = dp_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with WIDTH=32, DIGITS=8, REFRESH_DIV=4.
module tb_seg_display_ctrl;

  localparam int WIDTH       = 32;
  localparam int DIGITS      = 8;
  localparam int REFRESH_DIV = 4;

  // Hand-written active-low patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000;
  localparam logic [6:0] PA = 7'b0001000, PB = 7'b0000011, PD = 7'b0100001;
  localparam logic [6:0] PE = 7'b0000110, PF = 7'b0001110;
  localparam logic [6:0] PM = 7'b0111111, PX = 7'b1111111;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_value;
  logic [1:0]        mode;
  logic              blank_lz;
  logic [DIGITS-1:0] dp_mask;
  logic [6:0]        SEG;
  logic [DIGITS-1:0] AN;
  logic              DP;
  logic              overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seg_display_ctrl #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .mode     (mode),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .SEG      (SEG),
    .AN       (AN),
    .DP       (DP),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer; exp_lat = samples after the transfer edge until in_ready returns.
  task automatic send(input logic [31:0] v, input logic [1:0] m, input logic bl,
                      input int exp_lat, input string tag);
    int n;
    in_value = v;
    mode     = m;
    blank_lz = bl;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    tick();
    tick();
  endtask

  task automatic read_digit(input int i, output logic [6:0] seg);
    logic [7:0] an_exp;
    int n;
    an_exp = ~(8'h01 << i);
    n = 0;
    while (AN !== an_exp && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) check("scan_timeout", AN, an_exp);
    seg = SEG;
  endtask

  // exp holds digit i in bits [7*i +: 7].
  task automatic check_digits(input string tag, input logic [55:0] exp);
    logic [6:0] s;
    for (int i = 0; i < DIGITS; i++) begin
      read_digit(i, s);
      check($sformatf("%s_digit%0d", tag, i), s, exp[7*i +: 7]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k, bad, seen;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    mode     = 2'b00;
    blank_lz = 1'b0;
    dp_mask  = '0;
    repeat (3) tick();
    check("rst_ready", in_ready, 1);
    check("rst_overflow", overflow, 0);
    check("rst_seg", SEG, PX);
    check("rst_an", AN, 8'hFE);
    check("rst_dp", DP, 1);
    reset = 1'b0;
    tick();

    send(32'd12345678, 2'b00, 1'b1, 33, "udec");
    check("udec_overflow", overflow, 0);
    check_digits("udec", {P1, P2, P3, P4, P5, P6, P7, P8});

    send(32'hFFFFFFFB, 2'b01, 1'b1, 33, "sdec");
    check("sdec_overflow", overflow, 0);
    check_digits("sdec", {PX, PX, PX, PX, PX, PX, PM, P5});

    send(32'hDEADBEEF, 2'b10, 1'b0, 1, "hex");
    check("hex_overflow", overflow, 0);
    check_digits("hex", {PD, PE, PA, PD, PB, PE, PE, PF});

    send(32'd4294967295, 2'b00, 1'b0, 33, "big");
    check("big_overflow", overflow, 1);
    check_digits("big", {PM, PM, PM, PM, PM, PM, PM, PM});

    // Abort a decimal conversion with reset ten cycles after the transfer.
    in_value = 32'd99;
    mode     = 2'b00;
    blank_lz = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", in_ready, 1);
    check("abort_seg", SEG, PX);
    check("abort_overflow", overflow, 0);
    check("abort_an", AN, 8'hFE);
    repeat (40) tick();
    check_digits("abort", {PX, PX, PX, PX, PX, PX, PX, PX});

    send(32'd0, 2'b00, 1'b1, 33, "zero");
    check("zero_overflow", overflow, 0);
    check_digits("zero", {PX, PX, PX, PX, PX, PX, PX, P0});

    // Keep in_valid high with a new value while busy; it must not be taken.
    in_value = 32'd11;
    mode     = 2'b00;
    blank_lz = 1'b1;
    in_valid = 1'b1;
    tick();
    in_value = 32'd22;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("hold_latency", n, 33);
    tick();
    tick();
    check("hold_ready", in_ready, 1);
    check_digits("hold", {PX, PX, PX, PX, PX, PX, P1, P1});

    dp_mask = 8'h04;
    tick();
    tick();
    bad  = 0;
    seen = 0;
    repeat (40) begin
      tick();
      if (AN === 8'hFB) begin
        seen++;
        if (DP !== 1'b0) bad++;
      end else if (DP !== 1'b1) begin
        bad++;
      end
    end
    check("dp_bad_samples", bad, 0);
    check("dp_seen_digit2", seen, 4);

    n = 0;
    while (AN !== 8'h7F && n < 64) begin
      tick();
      n++;
    end
    k = 0;
    while (AN === 8'h7F && k < 16) begin
      tick();
      k++;
    end
    check("wrap_dwell", k, REFRESH_DIV);
    check("wrap_an", AN, 8'hFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
